// File: rtl/vga_plot_sink_if.sv
`default_nettype none
// =====================================================================
// Module   : vga_plot_sink_if
// Brief    : CPU-side plot bus: clear request, pixel write, ready.
// Revision : 1.0 - initial release
// =====================================================================
interface vga_plot_sink_if;
   logic        vga_resetn;
   logic        vga_plot;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [14:0] vga_color;
   logic        plot_ready;

   modport master (
      output vga_resetn,
      output vga_plot,
      output vga_x,
      output vga_y,
      output vga_color,
      input  plot_ready
   );

   modport slave (
      input  vga_resetn,
      input  vga_plot,
      input  vga_x,
      input  vga_y,
      input  vga_color,
      output plot_ready
   );
endinterface
`default_nettype wire

// File: rtl/vga_plot_sink.sv
`default_nettype none
// =====================================================================
// Module   : vga_plot_sink
// Brief    : Framebuffer with plot/clear write port and 4x4-scaled VGA scanout.
// Revision : 1.0 - initial release
// =====================================================================
module vga_plot_sink #(
   parameter int          WIDTH    = 160,
   parameter int          HEIGHT   = 120,
   parameter logic [14:0] BG_COLOR = 15'h0000,
   parameter int          H_VIS    = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_VIS    = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33
) (
   input  logic            clock,
   input  logic            resetn,
   vga_plot_sink_if.slave  plot_if,
   output logic            frame_start,
   output logic            VGA_CLK,
   output logic            VGA_HS,
   output logic            VGA_VS,
   output logic            VGA_BLANK_N,
   output logic            VGA_SYNC_N,
   output logic [9:0]      VGA_R,
   output logic [9:0]      VGA_G,
   output logic [9:0]      VGA_B
);

   localparam int c_DEPTH  = WIDTH * HEIGHT;
   localparam int c_ADDR_W = $clog2(c_DEPTH);
   localparam int c_H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int c_H_W    = $clog2(c_H_TOT);
   localparam int c_V_W    = $clog2(c_V_TOT);

   localparam logic [c_H_W-1:0]    c_H_LAST    = c_H_W'(c_H_TOT - 1);
   localparam logic [c_H_W-1:0]    c_H_VIS     = c_H_W'(H_VIS);
   localparam logic [c_H_W-1:0]    c_HS_BEG    = c_H_W'(H_VIS + H_FP);
   localparam logic [c_H_W-1:0]    c_HS_END    = c_H_W'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [c_V_W-1:0]    c_V_LAST    = c_V_W'(c_V_TOT - 1);
   localparam logic [c_V_W-1:0]    c_V_VIS     = c_V_W'(V_VIS);
   localparam logic [c_V_W-1:0]    c_V_VIS_M1  = c_V_W'(V_VIS - 1);
   localparam logic [c_V_W-1:0]    c_VS_BEG    = c_V_W'(V_VIS + V_FP);
   localparam logic [c_V_W-1:0]    c_VS_END    = c_V_W'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(c_DEPTH - 1);
   localparam logic [c_ADDR_W-1:0] c_WIDTH_A   = c_ADDR_W'(WIDTH);
   localparam logic [7:0]          c_X_LIM     = 8'(WIDTH);
   localparam logic [6:0]          c_Y_LIM     = 7'(HEIGHT);

   // ------------------------------------------------------------------
   // Write side: clear sweep / plot FSM
   // ------------------------------------------------------------------
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_ADDR_W-1:0]   r_clr_addr;
   logic [c_ADDR_W-1:0]   w_clr_addr_nxt;
   logic                  w_we;
   logic [c_ADDR_W-1:0]   w_waddr;
   logic [14:0]           w_wdata;
   logic                  w_in_range;
   logic [c_ADDR_W-1:0]   w_plot_addr;
   logic                  r_we;
   logic [c_ADDR_W-1:0]   r_waddr;
   logic [14:0]           r_wdata;

   assign w_in_range  = (plot_if.vga_x < c_X_LIM) && (plot_if.vga_y < c_Y_LIM);
   assign w_plot_addr = c_ADDR_W'(plot_if.vga_y) * c_WIDTH_A + c_ADDR_W'(plot_if.vga_x);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
         r_we       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
         r_we       <= w_we;
      end
   end

   always_ff @(posedge clock) begin
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      w_we           = 1'b0;
      w_waddr        = r_clr_addr;
      w_wdata        = BG_COLOR;
      case (r_state)
         ST_CLEAR: begin
            if (!plot_if.vga_resetn) begin
               w_clr_addr_nxt = '0;
            end else begin
               w_we = 1'b1;
               if (r_clr_addr == c_ADDR_LAST) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_clr_addr_nxt = r_clr_addr + 1'b1;
               end
            end
         end
         ST_IDLE: begin
            // A clear request wins over a plot issued in the same cycle.
            if (!plot_if.vga_resetn) begin
               w_state_nxt    = ST_CLEAR;
               w_clr_addr_nxt = '0;
            end else if (plot_if.vga_plot && w_in_range) begin
               w_we    = 1'b1;
               w_waddr = w_plot_addr;
               w_wdata = plot_if.vga_color;
            end
         end
         default: begin
            w_state_nxt    = ST_CLEAR;
            w_clr_addr_nxt = '0;
         end
      endcase
   end

   assign plot_if.plot_ready = (r_state == ST_IDLE);

   // ------------------------------------------------------------------
   // Pixel timing
   // ------------------------------------------------------------------
   logic                r_pix_en;
   logic [c_H_W-1:0]    r_h_cnt;
   logic [c_V_W-1:0]    r_v_cnt;
   logic                r_frame_start;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_pix_en      <= 1'b0;
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_pix_en      <= ~r_pix_en;
         r_frame_start <= 1'b0;
         if (r_pix_en) begin
            if (r_h_cnt == c_H_LAST) begin
               r_h_cnt       <= '0;
               r_frame_start <= (r_v_cnt == c_V_VIS_M1);
               if (r_v_cnt == c_V_LAST) begin
                  r_v_cnt <= '0;
               end else begin
                  r_v_cnt <= r_v_cnt + 1'b1;
               end
            end else begin
               r_h_cnt <= r_h_cnt + 1'b1;
            end
         end
      end
   end

   logic                w_visible;
   logic                w_hs_n;
   logic                w_vs_n;
   logic [c_ADDR_W-1:0] w_raddr;

   assign w_visible = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
   assign w_hs_n    = !((r_h_cnt >= c_HS_BEG) && (r_h_cnt <= c_HS_END));
   assign w_vs_n    = !((r_v_cnt >= c_VS_BEG) && (r_v_cnt <= c_VS_END));
   assign w_raddr   = w_visible ?
                      (c_ADDR_W'(r_v_cnt >> 2) * c_WIDTH_A + c_ADDR_W'(r_h_cnt >> 2)) : '0;

   // ------------------------------------------------------------------
   // Framebuffer: simple dual-port, read-old-data on collision
   // ------------------------------------------------------------------
   logic [14:0] r_mem [c_DEPTH];
   logic [14:0] r_rdata;

   always_ff @(posedge clock) begin
      if (r_we) begin
         r_mem[r_waddr] <= r_wdata;
      end
      r_rdata <= r_mem[w_raddr];
   end

   // ------------------------------------------------------------------
   // Output pipeline: stage 1 aligns with the RAM read, stage 2 drives pins
   // ------------------------------------------------------------------
   logic       r_s1_hs_n;
   logic       r_s1_vs_n;
   logic       r_s1_vis;
   logic       r_vga_clk;
   logic       r_hs_n;
   logic       r_vs_n;
   logic       r_blank_n;
   logic [9:0] r_red;
   logic [9:0] r_grn;
   logic [9:0] r_blu;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_s1_hs_n <= 1'b1;
         r_s1_vs_n <= 1'b1;
         r_s1_vis  <= 1'b0;
         r_vga_clk <= 1'b0;
         r_hs_n    <= 1'b1;
         r_vs_n    <= 1'b1;
         r_blank_n <= 1'b0;
         r_red     <= '0;
         r_grn     <= '0;
         r_blu     <= '0;
      end else begin
         r_s1_hs_n <= w_hs_n;
         r_s1_vs_n <= w_vs_n;
         r_s1_vis  <= w_visible;
         r_vga_clk <= r_pix_en;
         r_hs_n    <= r_s1_hs_n;
         r_vs_n    <= r_s1_vs_n;
         r_blank_n <= r_s1_vis;
         if (r_s1_vis) begin
            r_red <= {r_rdata[14:10], r_rdata[14:10]};
            r_grn <= {r_rdata[9:5],   r_rdata[9:5]};
            r_blu <= {r_rdata[4:0],   r_rdata[4:0]};
         end else begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
         end
      end
   end

   assign frame_start = r_frame_start;
   assign VGA_CLK     = r_vga_clk;
   assign VGA_HS      = r_hs_n;
   assign VGA_VS      = r_vs_n;
   assign VGA_BLANK_N = r_blank_n;
   assign VGA_SYNC_N  = 1'b1;
   assign VGA_R       = r_red;
   assign VGA_G       = r_grn;
   assign VGA_B       = r_blu;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_sink.sv
`default_nettype none
// =====================================================================
// Module   : tb_vga_plot_sink
// Brief    : Scoreboard bench for vga_plot_sink on a reduced 16x12 raster.
// Revision : 1.0 - initial release
// =====================================================================
module tb_vga_plot_sink;

   localparam int          W     = 16;
   localparam int          H     = 12;
   localparam int          DEPTH = W * H;
   localparam logic [14:0] BG    = 15'h1CE7;
   localparam int HV = 64, HF = 4, HS = 8, HB = 4;
   localparam int VV = 48, VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       frame_start, vga_clk, hs_n, vs_n, blank_n, sync_n;
   logic [9:0] vr, vg, vb;

   vga_plot_sink_if pif ();

   vga_plot_sink #(
      .WIDTH(W), .HEIGHT(H), .BG_COLOR(BG),
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clock(clk), .resetn(resetn), .plot_if(pif),
      .frame_start(frame_start), .VGA_CLK(vga_clk), .VGA_HS(hs_n), .VGA_VS(vs_n),
      .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int rst_edge = 0;
   bit running = 1'b0;
   int n_checks = 0;
   int n_errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0d: got %0h, expected %0h", nm, t, act, exp);
      end
   endtask

   // Reference model: framebuffer contents plus when plot_ready is due.
   logic [14:0] fb   [DEPTH];
   bit          fb_ok[DEPTH];
   int          fb_t [DEPTH];
   int          ready_at = DEPTH;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        bl;
      logic        chk;
      logic [14:0] col;
   } pix_t;
   pix_t exp_q[$];

   int   mt2, ma, mn, mh, mv;
   pix_t e;

   always @(negedge clk) begin
      if (running) begin
         mt2 = cyc - rst_edge;
         check("plot_ready", mt2, 32'(pif.plot_ready), 32'(mt2 >= ready_at));
         if (mt2 == ready_at) begin
            for (int i = 0; i < DEPTH; i++) begin
               fb[i] = BG; fb_ok[i] = 1'b1; fb_t[i] = mt2;
            end
         end
         if (!pif.vga_resetn) begin
            ready_at = mt2 + 1 + DEPTH;
            for (int i = 0; i < DEPTH; i++) fb_ok[i] = 1'b0;
         end else if (pif.vga_plot && mt2 >= ready_at && pif.vga_x < W && pif.vga_y < H) begin
            ma = int'(pif.vga_y) * W + int'(pif.vga_x);
            fb[ma] = pif.vga_color; fb_t[ma] = mt2;
         end
         // Pixel n enters the counters at t=2n and leaves the pins at t=2n+2.
         if (mt2 % 2 == 0) begin
            mn = mt2 / 2;
            mh = mn % HT;
            mv = (mn / HT) % VT;
            e.bl  = (mh < HV) && (mv < VV);
            e.hs  = !(mh >= HV + HF && mh < HV + HF + HS);
            e.vs  = !(mv >= VV + VF && mv < VV + VF + VS);
            e.chk = 1'b1;
            e.col = '0;
            if (e.bl) begin
               ma = (mv / 4) * W + (mh / 4);
               e.col = fb[ma];
               e.chk = fb_ok[ma] && (mt2 - fb_t[ma] >= 4);
            end
            exp_q.push_back(e);
         end
      end
   end

   int          mt;
   int          last_fs = -1;
   int          cnt_hs = 0, cnt_vs = 0, cnt_bl = 0, n_rgb = 0;
   pix_t        cur;
   logic [29:0] exp_rgb;

   always @(negedge clk) begin
      if (running) begin
         #1;
         mt = cyc - rst_edge;
         check("frame_start", mt, 32'(frame_start),
               32'(mt > 0 && mt % 2 == 0 && (mt / 2) % FRAME == VV * HT));
         check("vga_clk", mt, 32'(vga_clk), 32'(mt >= 2 && mt % 2 == 0));
         check("sync_n", mt, 32'(sync_n), 32'd1);
         if (mt < 2) begin
            check("reset_hs", mt, 32'(hs_n), 32'd1);
            check("reset_vs", mt, 32'(vs_n), 32'd1);
            check("reset_blank", mt, 32'(blank_n), 32'd0);
            check("reset_rgb", mt, 32'({vr, vg, vb}), 32'd0);
         end else if (mt % 2 == 0) begin
            if (exp_q.size() == 0) begin
               check("queue_underrun", mt, 32'd0, 32'd1);
            end else begin
               cur = exp_q.pop_front();
               check("hsync", mt, 32'(hs_n), 32'(cur.hs));
               check("vsync", mt, 32'(vs_n), 32'(cur.vs));
               check("blank_n", mt, 32'(blank_n), 32'(cur.bl));
               if (cur.chk) begin
                  exp_rgb = {cur.col[14:10], cur.col[14:10], cur.col[9:5], cur.col[9:5],
                             cur.col[4:0], cur.col[4:0]};
                  check("rgb", mt, 32'({vr, vg, vb}), 32'(exp_rgb));
                  n_rgb++;
               end
            end
         end
         if (frame_start) begin
            if (last_fs >= 0) begin
               check("frame_period", mt, 32'(mt - last_fs), 32'(2 * FRAME));
               check("hs_low_clocks", mt, 32'(cnt_hs), 32'(2 * HS * VT));
               check("vs_low_clocks", mt, 32'(cnt_vs), 32'(2 * VS * HT));
               check("blank_hi_clocks", mt, 32'(cnt_bl), 32'(2 * HV * VV));
            end
            last_fs = mt;
            cnt_hs = 0; cnt_vs = 0; cnt_bl = 0;
         end
         if (!hs_n) cnt_hs++;
         if (!vs_n) cnt_vs++;
         if (blank_n) cnt_bl++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic plot(input int x, input int y, input logic [14:0] c);
      pif.vga_plot  = 1'b1;
      pif.vga_x     = 8'(x);
      pif.vga_y     = 7'(y);
      pif.vga_color = c;
      tick(1);
      pif.vga_plot  = 1'b0;
   endtask

   task automatic pulse_clear();
      pif.vga_resetn = 1'b0;
      tick(1);
      pif.vga_resetn = 1'b1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!pif.plot_ready && k < 4 * DEPTH) begin
         tick(1);
         k++;
      end
      n_checks++;
      if (!pif.plot_ready) begin
         n_errors++;
         $display("FAIL wait_ready: plot_ready=%0b after %0d cycles, expected 1", pif.plot_ready, k);
      end
   endtask

   initial begin
      pif.vga_resetn = 1'b1;
      pif.vga_plot   = 1'b0;
      pif.vga_x      = '0;
      pif.vga_y      = '0;
      pif.vga_color  = '0;
      repeat (3) @(posedge clk);
      #1;
      resetn   = 1'b1;
      rst_edge = cyc;
      running  = 1'b1;

      wait_ready();
      plot(5, 2, 15'h7C00);
      plot(W, 0, 15'h001F);
      plot(160, 0, 15'h001F);
      plot(0, H, 15'h03E0);
      plot(W - 1, H - 1, 15'h7FFF);
      plot(0, 0, 15'h4210);
      tick(2 * FRAME + 8);

      plot(3, 3, 15'h7FFF);
      tick(4);
      pulse_clear();
      tick(50);
      pulse_clear();
      tick(100);
      plot(0, 0, 15'h7FFF);
      wait_ready();

      pif.vga_plot   = 1'b1;
      pif.vga_x      = 8'd1;
      pif.vga_y      = 7'd1;
      pif.vga_color  = 15'h03E0;
      pif.vga_resetn = 1'b0;
      tick(1);
      pif.vga_plot   = 1'b0;
      pif.vga_resetn = 1'b1;
      wait_ready();
      plot(7, 9, 15'h2D6B);
      plot(2, 11, 15'h5555);
      tick(2 * FRAME + 8);

      for (int i = 0; i < 2 * FRAME; i++) begin
         pif.vga_plot = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) pif.vga_x = 8'($urandom_range(W, 255));
         else                            pif.vga_x = 8'($urandom_range(0, W - 1));
         if ($urandom_range(0, 15) == 0) pif.vga_y = 7'($urandom_range(H, 127));
         else                            pif.vga_y = 7'($urandom_range(0, H - 1));
         pif.vga_color  = 15'($urandom);
         pif.vga_resetn = ($urandom_range(0, 799) != 0);
         tick(1);
      end
      pif.vga_plot   = 1'b0;
      pif.vga_resetn = 1'b1;
      tick(8);
      running = 1'b0;
      check("rgb_coverage", 0, 32'(n_rgb > FRAME), 32'd1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
